// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a fixed-latency single-ported memory.
// Optional IF starvation guard: define MEM_ARB_STARVE_GUARD_EN.
module mem_port_arbiter #(
    parameter int MEM_LAT    = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        dm_req,
    input  logic        dm_we,
    input  logic        dm_byte,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic        mem_byte,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_param
        $error("mem_port_arbiter: parameter out of range");
    end

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_DM} owner_t;

    localparam logic [2:0] LAT_M1 = 3'(MEM_LAT - 1);

    state_t     state, state_nxt;
    owner_t     owner, owner_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       owner_we, owner_we_nxt;
    logic       done;
    logic       can_grant;
    logic       if_first;

    assign done      = (state == BUSY) && (cnt == 3'd0);
    assign can_grant = !rst && ((state == IDLE) || done);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    logic [3:0] starve;

    // IF overrides DM once DM has won STARVE_MAX times in a row over a waiting fetch
    assign if_first = if_req && (!dm_req || (starve == STARVE_LIM));

    always_ff @(posedge clk) begin
        if (rst) begin
            starve <= 4'd0;
        end else if (!if_req || if_gnt) begin
            starve <= 4'd0;
        end else if (dm_gnt) begin
            starve <= starve + 4'd1;
        end
    end
`else
    assign if_first = if_req && !dm_req;
`endif

    assign if_gnt = can_grant && if_first;
    assign dm_gnt = can_grant && dm_req && !if_first;

    always_comb begin
        state_nxt    = state;
        owner_nxt    = owner;
        owner_we_nxt = owner_we;
        cnt_nxt      = cnt;
        if (state == BUSY && cnt != 3'd0) begin
            cnt_nxt = cnt - 3'd1;
        end
        if (done) begin
            state_nxt    = IDLE;
            owner_nxt    = OWN_NONE;
            owner_we_nxt = 1'b0;
        end
        if (if_gnt || dm_gnt) begin
            state_nxt    = BUSY;
            cnt_nxt      = LAT_M1;
            owner_nxt    = dm_gnt ? OWN_DM : OWN_IF;
            owner_we_nxt = dm_gnt && dm_we;
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_byte  = 1'b0;
        mem_addr  = 32'd0;
        mem_wdata = 32'd0;
        if (dm_gnt) begin
            mem_en    = 1'b1;
            mem_we    = dm_we;
            mem_byte  = dm_byte;
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (if_gnt) begin
            mem_en   = 1'b1;
            mem_addr = if_addr;
        end
    end

    // Response routed by the latched owner; stores return an ack with zero data
    always_comb begin
        if_rvalid = !rst && done && (owner == OWN_IF);
        dm_rvalid = !rst && done && (owner == OWN_DM);
        if_rdata  = if_rvalid ? mem_rdata : 32'd0;
        dm_rdata  = (dm_rvalid && !owner_we) ? mem_rdata : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            owner    <= OWN_NONE;
            owner_we <= 1'b0;
            cnt      <= 3'd0;
        end else begin
            state    <= state_nxt;
            owner    <= owner_nxt;
            owner_we <= owner_we_nxt;
            cnt      <= cnt_nxt;
        end
    end

endmodule
